// File: rtl/ctrl_step_scheduler.sv
// Step scheduler: walks a one-hot step across the bits set in a command
// frame's ctrl mask, dwelling time_ctrl sclk cycles per step.
//
// Ports:
//   sclk, rst       clock, synchronous active-high reset
//   cfg_valid       1-cycle pulse: ctrl/time_ctrl hold a new committed frame
//   ctrl            step-enable mask
//   time_ctrl       dwell per step in sclk cycles (0 treated as 1)
//   hold            freeze dwell counter and step while running
//   led             one-hot current step, 0 when idle
//   cur_step        index of current step
//   step_tick       1-cycle pulse on each step change or restart
//   busy            1 while running
//   cfg_pending     a shadow frame is waiting for a step boundary
module ctrl_step_scheduler #(
    parameter int CTRL_W = 8,
    parameter int TIME_W = 32
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              cfg_valid,
    input  logic [CTRL_W-1:0] ctrl,
    input  logic [TIME_W-1:0] time_ctrl,
    input  logic              hold,
    output logic [CTRL_W-1:0] led,
    output logic [2:0]        cur_step,
    output logic              step_tick,
    output logic              busy,
    output logic              cfg_pending
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CTRL_W-1:0] r_pend_mask, w_pend_mask_nxt;
    logic [TIME_W-1:0] r_pend_per, w_pend_per_nxt;
    logic [CTRL_W-1:0] r_act_mask, w_act_mask_nxt;
    logic [TIME_W-1:0] r_act_per, w_act_per_nxt;
    logic [TIME_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]        r_cur, w_cur_nxt;
    logic              r_tick, w_tick_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_pending, w_pending_nxt;
    logic [CTRL_W-1:0] r_led, w_led_nxt;

    logic       w_boundary;
    logic [2:0] w_low;
    logic [2:0] w_next;
    logic [2:0] w_idx;

    // Lowest set bit of the shadow mask (start step of a new frame).
    always_comb begin
        w_low = 3'd0;
        for (int i = CTRL_W - 1; i >= 0; i--) begin
            if (r_pend_mask[i]) w_low = 3'(i);
        end
    end

    // Next set bit after the current step, circular. Searching from the
    // farthest offset down lets the nearest hit win. A single-bit mask
    // finds nothing and keeps the current step.
    always_comb begin
        w_next = r_cur;
        w_idx  = r_cur;
        for (int i = CTRL_W - 1; i >= 1; i--) begin
            w_idx = r_cur + 3'(i);
            if (r_act_mask[w_idx]) w_next = w_idx;
        end
    end

    assign w_boundary = (r_cnt == r_act_per - TIME_W'(1));

    always_comb begin
        w_state_nxt     = r_state;
        w_pend_mask_nxt = r_pend_mask;
        w_pend_per_nxt  = r_pend_per;
        w_act_mask_nxt  = r_act_mask;
        w_act_per_nxt   = r_act_per;
        w_cnt_nxt       = r_cnt;
        w_cur_nxt       = r_cur;
        w_tick_nxt      = 1'b0;
        w_busy_nxt      = r_busy;
        w_pending_nxt   = r_pending;

        if (cfg_valid) begin
            w_pend_mask_nxt = ctrl;
            w_pend_per_nxt  = (time_ctrl == '0) ? TIME_W'(1) : time_ctrl;
            w_pending_nxt   = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (r_pending) begin
                    w_state_nxt    = S_RUN;
                    w_act_mask_nxt = r_pend_mask;
                    w_act_per_nxt  = r_pend_per;
                    w_cnt_nxt      = '0;
                    // A frame arriving on the apply edge stays pending.
                    if (!cfg_valid) w_pending_nxt = 1'b0;
                end
            end
            S_RUN: begin
                if (hold) begin
                    w_cnt_nxt = r_cnt;
                end else if (!w_boundary) begin
                    w_cnt_nxt = r_cnt + TIME_W'(1);
                end else if (r_pending) begin
                    w_act_mask_nxt = r_pend_mask;
                    w_act_per_nxt  = r_pend_per;
                    w_cnt_nxt      = '0;
                    if (!cfg_valid) w_pending_nxt = 1'b0;
                end else begin
                    w_cnt_nxt  = '0;
                    w_cur_nxt  = w_next;
                    w_tick_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Shared tail of a frame apply: start or go idle on a zero mask.
        if (r_pending && (r_state == S_IDLE ||
                          (!hold && w_boundary))) begin
            if (r_pend_mask != '0) begin
                w_state_nxt = S_RUN;
                w_cur_nxt   = w_low;
                w_tick_nxt  = 1'b1;
                w_busy_nxt  = 1'b1;
            end else begin
                w_state_nxt = S_IDLE;
                w_cur_nxt   = 3'd0;
                w_tick_nxt  = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        end

        w_led_nxt = w_busy_nxt ? (CTRL_W'(1) << w_cur_nxt) : '0;
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            r_pend_mask <= '0;
            r_pend_per  <= '0;
            r_act_mask  <= '0;
            r_act_per   <= '0;
            r_cnt       <= '0;
            r_cur       <= '0;
            r_tick      <= 1'b0;
            r_busy      <= 1'b0;
            r_pending   <= 1'b0;
            r_led       <= '0;
        end else begin
            r_pend_mask <= w_pend_mask_nxt;
            r_pend_per  <= w_pend_per_nxt;
            r_act_mask  <= w_act_mask_nxt;
            r_act_per   <= w_act_per_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cur       <= w_cur_nxt;
            r_tick      <= w_tick_nxt;
            r_busy      <= w_busy_nxt;
            r_pending   <= w_pending_nxt;
            r_led       <= w_led_nxt;
        end
    end

    assign led         = r_led;
    assign cur_step    = r_cur;
    assign step_tick   = r_tick;
    assign busy        = r_busy;
    assign cfg_pending = r_pending;

endmodule

// File: tb/tb_ctrl_step_scheduler.sv
// Directed bench for ctrl_step_scheduler: reset, mask walk, double
// buffering, zero period, hold and zero-mask idle/restart.
module tb_ctrl_step_scheduler;

    logic        sclk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic [7:0]  ctrl;
    logic [31:0] time_ctrl;
    logic        hold;
    logic [7:0]  led;
    logic [2:0]  cur_step;
    logic        step_tick;
    logic        busy;
    logic        cfg_pending;

    int checks   = 0;
    int failures = 0;

    ctrl_step_scheduler #(.CTRL_W(8), .TIME_W(32)) dut (
        .sclk       (sclk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .ctrl       (ctrl),
        .time_ctrl  (time_ctrl),
        .hold       (hold),
        .led        (led),
        .cur_step   (cur_step),
        .step_tick  (step_tick),
        .busy       (busy),
        .cfg_pending(cfg_pending)
    );

    always #5 sclk = ~sclk;

    // Advance one edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cfg_valid = 1'b0;
        hold = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] m, input logic [31:0] t);
        cfg_valid = 1'b1;
        ctrl = m;
        time_ctrl = t;
        step();
        cfg_valid = 1'b0;
    endtask

    logic [7:0] seq2 [3];
    logic [7:0] exp_led;

    initial begin
        rst = 1'b1;
        cfg_valid = 1'b0;
        ctrl = '0;
        time_ctrl = '0;
        hold = 1'b0;
        seq2[0] = 8'h04;
        seq2[1] = 8'h20;
        seq2[2] = 8'h80;
        step();
        step();
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_pend", 32'(cfg_pending), 32'h0);
        rst = 1'b0;

        // Mask A4, period 3: 04,20,80,04 with a tick on each change.
        send(8'hA4, 32'd3);
        chk("t2_pend", 32'(cfg_pending), 32'h1);
        chk("t2_idle", 32'(busy), 32'h0);
        step();
        chk("t2_cur", 32'(cur_step), 32'd2);
        chk("t2_pclr", 32'(cfg_pending), 32'h0);
        for (int n = 0; n < 10; n++) begin
            if (n > 0) step();
            exp_led = seq2[(n / 3) % 3];
            chk("t2_led", 32'(led), 32'(exp_led));
            chk("t2_tick", 32'(step_tick), (n % 3 == 0) ? 32'h1 : 32'h0);
            chk("t2_busy", 32'(busy), 32'h1);
        end

        // Reset mid-run with a frame on the same edge.
        rst = 1'b1;
        cfg_valid = 1'b1;
        ctrl = 8'hFF;
        time_ctrl = 32'd1;
        step();
        rst = 1'b0;
        cfg_valid = 1'b0;
        chk("t1_led", 32'(led), 32'h0);
        chk("t1_busy", 32'(busy), 32'h0);
        chk("t1_tick", 32'(step_tick), 32'h0);
        chk("t1_cur", 32'(cur_step), 32'h0);
        chk("t1_pend", 32'(cfg_pending), 32'h0);
        step();
        step();
        chk("t1_stay", 32'(busy), 32'h0);

        // Period 10 on bit 1; new frame captured on the edge giving cnt=4.
        send(8'h02, 32'd10);
        step();
        chk("t3_led0", 32'(led), 32'h02);
        step();
        step();
        step();
        send(8'h01, 32'd2);
        for (int n = 0; n < 6; n++) begin
            if (n > 0) step();
            chk("t3_pend", 32'(cfg_pending), 32'h1);
            chk("t3_old", 32'(led), 32'h02);
        end
        step();
        chk("t3_pclr", 32'(cfg_pending), 32'h0);
        chk("t3_new", 32'(led), 32'h01);
        chk("t3_ntick", 32'(step_tick), 32'h1);
        for (int n = 1; n < 6; n++) begin
            step();
            chk("t3_led", 32'(led), 32'h01);
            chk("t3_tick", 32'(step_tick), (n % 2 == 0) ? 32'h1 : 32'h0);
        end

        // Zero period on a full mask: one step per cycle.
        do_reset();
        send(8'hFF, 32'd0);
        for (int n = 0; n < 9; n++) begin
            step();
            exp_led = 8'h01 << (n % 8);
            chk("t4_led", 32'(led), 32'(exp_led));
            chk("t4_tick", 32'(step_tick), 32'h1);
        end

        // Hold 5 cycles mid-step, period 4: first step spans 9 cycles.
        do_reset();
        send(8'h03, 32'd4);
        step();
        chk("t5_led0", 32'(led), 32'h01);
        step();
        hold = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step();
            chk("t5_hled", 32'(led), 32'h01);
            chk("t5_htick", 32'(step_tick), 32'h0);
        end
        hold = 1'b0;
        step();
        chk("t5_c2", 32'(led), 32'h01);
        step();
        chk("t5_c3", 32'(led), 32'h01);
        step();
        chk("t5_next", 32'(led), 32'h02);
        chk("t5_tick", 32'(step_tick), 32'h1);

        // Zero mask goes idle at the boundary; later frame restarts
        // even with hold asserted in idle.
        send(8'h00, 32'd1);
        chk("t6_pend", 32'(cfg_pending), 32'h1);
        step();
        step();
        chk("t6_run", 32'(busy), 32'h1);
        step();
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_led", 32'(led), 32'h0);
        chk("t6_tick", 32'(step_tick), 32'h0);
        chk("t6_pclr", 32'(cfg_pending), 32'h0);
        step();
        chk("t6_idle", 32'(busy), 32'h0);
        hold = 1'b1;
        send(8'h10, 32'd5);
        step();
        chk("t6_rled", 32'(led), 32'h10);
        chk("t6_rcur", 32'(cur_step), 32'd4);
        chk("t6_rtick", 32'(step_tick), 32'h1);
        step();
        chk("t6_hold", 32'(step_tick), 32'h0);
        chk("t6_hled", 32'(led), 32'h10);
        hold = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
